// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: line-granular memory responder for the channel-2 cache bus (A2/D2/C2).
// Define MEM_LINE_CTRL_OOR_CHECK_EN to widen A2_IN by one bit and flag out-of-range lines on ERR.
module mem_line_ctrl #(
  parameter int unsigned MEM_BYTES  = 524288,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LATENCY    = 100
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic [1:0]                             C2_IN,
`ifdef MEM_LINE_CTRL_OOR_CHECK_EN
  input  logic [$clog2(MEM_BYTES/LINE_BYTES):0]   A2_IN,
`else
  input  logic [$clog2(MEM_BYTES/LINE_BYTES)-1:0] A2_IN,
`endif
  input  logic [DATA_W-1:0]                      D2_IN,
  output logic [1:0]                             C2_OUT,
  output logic [DATA_W-1:0]                      D2_OUT,
  output logic                                   BUSY,
  output logic                                   ERR
);

  localparam int LINES      = MEM_BYTES / LINE_BYTES;
  localparam int LA_W       = $clog2(LINES);
  localparam int BA_W       = $clog2(MEM_BYTES);
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int BEATS      = LINE_W / DATA_W;
  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int BC_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] CmdRead  = 2'd1;
  localparam logic [1:0] CmdWrite = 2'd2;
  localparam logic [1:0] RspNop   = 2'd0;
  localparam logic [1:0] RspResp  = 2'd3;

  typedef enum logic [1:0] {StIdle, StWrx, StWait, StResp} state_e;

  state_e              r_state;
  logic [LA_W-1:0]     r_addr;
  logic                r_is_wr;
  logic                r_oor;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [BC_W-1:0]     r_beat_cnt;
  logic [LINE_W-1:0]   r_line_buf;
  logic [1:0]          r_c2_out;
  logic [DATA_W-1:0]   r_d2_out;
  logic                r_busy;
  logic                r_err;
  logic [7:0]          r_mem [MEM_BYTES];

  logic [LA_W-1:0]     w_cmd_la;
  logic                w_cmd_oor;
  logic [BC_W-1:0]     w_rd_idx;
  logic [BA_W-1:0]     w_rd_base;
  logic [DATA_W-1:0]   w_rd_beat;
  logic                w_commit;
  logic [LA_W-1:0]     w_wr_la;
  logic [BA_W-1:0]     w_wr_base;
  logic [LINE_W-1:0]   w_wr_line;

  assign w_cmd_la = A2_IN[LA_W-1:0];
`ifdef MEM_LINE_CTRL_OOR_CHECK_EN
  assign w_cmd_oor = (A2_IN >= (LA_W+1)'(LINES));
`else
  assign w_cmd_oor = 1'b0;
`endif

  assign C2_OUT = r_c2_out;
  assign D2_OUT = r_d2_out;
  assign BUSY   = r_busy;
  assign ERR    = r_err;

  // Beat about to be presented: beat 0 when leaving WAIT, otherwise the one after the current beat.
  always_comb begin
    w_rd_idx  = (r_state == StWait) ? '0 : r_beat_cnt + 1'b1;
    w_rd_base = BA_W'(r_addr) * BA_W'(LINE_BYTES) + BA_W'(w_rd_idx) * BA_W'(BEAT_BYTES);
    w_rd_beat = '0;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      w_rd_beat[8*j +: 8] = r_mem[w_rd_base + BA_W'(j)];
    end
    if (r_oor) begin
      w_rd_beat = '0;
    end
  end

  // The last beat is committed straight from D2_IN, so a reset before it leaves the array intact.
  always_comb begin
    w_commit = 1'b0;
    w_wr_la  = r_addr;
    if (r_state == StWrx && r_beat_cnt == BC_W'(BEATS - 1)) begin
      w_commit = !r_oor;
    end else if (r_state == StIdle && C2_IN == CmdWrite && BEATS == 1) begin
      w_commit = !w_cmd_oor;
      w_wr_la  = w_cmd_la;
    end
    w_wr_base = BA_W'(w_wr_la) * BA_W'(LINE_BYTES);
    w_wr_line = r_line_buf;
    w_wr_line[(BEATS-1)*DATA_W +: DATA_W] = D2_IN;
  end

  always_ff @(posedge CLK) begin
    if (w_commit) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        r_mem[w_wr_base + BA_W'(b)] <= w_wr_line[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_is_wr    <= 1'b0;
      r_oor      <= 1'b0;
      r_lat_cnt  <= '0;
      r_beat_cnt <= '0;
      r_line_buf <= '0;
      r_c2_out   <= RspNop;
      r_d2_out   <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_c2_out <= RspNop;
          r_d2_out <= '0;
          r_err    <= 1'b0;
          if (C2_IN == CmdRead) begin
            r_addr    <= w_cmd_la;
            r_is_wr   <= 1'b0;
            r_oor     <= w_cmd_oor;
            r_lat_cnt <= LAT_W'(LATENCY - 1);
            r_busy    <= 1'b1;
            r_state   <= StWait;
          end else if (C2_IN == CmdWrite) begin
            r_addr               <= w_cmd_la;
            r_is_wr              <= 1'b1;
            r_oor                <= w_cmd_oor;
            r_line_buf[DATA_W-1:0] <= D2_IN;
            r_busy               <= 1'b1;
            if (BEATS == 1) begin
              r_lat_cnt <= LAT_W'(LATENCY - 1);
              r_state   <= StWait;
            end else begin
              r_beat_cnt <= BC_W'(1);
              r_state    <= StWrx;
            end
          end
        end
        StWrx: begin
          r_line_buf[r_beat_cnt*DATA_W +: DATA_W] <= D2_IN;
          if (r_beat_cnt == BC_W'(BEATS - 1)) begin
            r_lat_cnt <= LAT_W'(LATENCY - 1);
            r_state   <= StWait;
          end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        StWait: begin
          if (r_lat_cnt == '0) begin
            r_beat_cnt <= '0;
            r_c2_out   <= RspResp;
            r_d2_out   <= r_is_wr ? '0 : w_rd_beat;
            r_err      <= r_oor;
            r_state    <= StResp;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        StResp: begin
          if (r_is_wr || r_beat_cnt == BC_W'(BEATS - 1)) begin
            r_c2_out <= RspNop;
            r_d2_out <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= StIdle;
          end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_d2_out   <= w_rd_beat;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed bench for mem_line_ctrl: three instances cover latency 4, latency 1 and a 32-bit bus.
module tb_mem_line_ctrl;

`ifdef MEM_LINE_CTRL_OOR_CHECK_EN
  localparam int AW = 7;
`else
  localparam int AW = 6;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    a_c2, a_c2o, b_c2, b_c2o, c_c2, c_c2o;
  logic [AW-1:0] a_a2, b_a2, c_a2;
  logic [15:0]   a_d2, a_d2o, b_d2, b_d2o;
  logic [31:0]   c_d2, c_d2o;
  logic          a_busy, a_err, b_busy, b_err, c_busy, c_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_line_ctrl #(.MEM_BYTES(1024), .LINE_BYTES(16), .DATA_W(16), .LATENCY(4)) u_a (
    .CLK(clk), .RESET(rst_n), .C2_IN(a_c2), .A2_IN(a_a2), .D2_IN(a_d2),
    .C2_OUT(a_c2o), .D2_OUT(a_d2o), .BUSY(a_busy), .ERR(a_err));

  mem_line_ctrl #(.MEM_BYTES(1024), .LINE_BYTES(16), .DATA_W(16), .LATENCY(1)) u_b (
    .CLK(clk), .RESET(rst_n), .C2_IN(b_c2), .A2_IN(b_a2), .D2_IN(b_d2),
    .C2_OUT(b_c2o), .D2_OUT(b_d2o), .BUSY(b_busy), .ERR(b_err));

  mem_line_ctrl #(.MEM_BYTES(1024), .LINE_BYTES(16), .DATA_W(32), .LATENCY(2)) u_c (
    .CLK(clk), .RESET(rst_n), .C2_IN(c_c2), .A2_IN(c_a2), .D2_IN(c_d2),
    .C2_OUT(c_c2o), .D2_OUT(c_d2o), .BUSY(c_busy), .ERR(c_err));

  // Drives an 8-beat write on u_a; returns #1 after the edge that takes the last beat.
  task automatic a_write(input logic [AW-1:0] addr, input logic [127:0] line);
    a_c2 = 2'd2; a_a2 = addr; a_d2 = line[15:0];
    @(posedge clk); #1;
    a_c2 = 2'd0;
    for (int i = 1; i < 8; i++) begin
      a_d2 = line[16*i +: 16];
      @(posedge clk); #1;
    end
    a_d2 = '0;
  endtask

  task automatic a_read(input logic [AW-1:0] addr, input bit drop_wr);
    a_c2 = 2'd1; a_a2 = addr;
    @(posedge clk); #1;
    if (drop_wr) begin
      a_c2 = 2'd2; a_a2 = 2; a_d2 = 16'hDEAD;
    end else begin
      a_c2 = 2'd0;
    end
  endtask

  // Gathers u_a responses until BUSY drops; cycle numbers count edges after the call.
  task automatic a_collect(input int hold, output int first, output int nresp,
                           output logic [127:0] data, output int errc, output bit tmo);
    first = -1; nresp = 0; data = '0; errc = 0; tmo = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      if (n > hold) a_c2 = 2'd0;
      @(posedge clk); #1;
      if (a_c2o == 2'd3) begin
        if (first < 0) first = n;
        if (nresp < 8) data[16*nresp +: 16] = a_d2o;
        nresp++;
        if (a_err) errc++;
      end
      if (!a_busy) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({a_c2o, a_d2o, a_busy, a_err} !== '0) begin
      n_bad++; $display("FAIL reset_a: got %h want 0", {a_c2o, a_d2o, a_busy, a_err});
    end
    n_cmp++;
    if ({b_c2o, b_d2o, b_busy, b_err} !== '0) begin
      n_bad++; $display("FAIL reset_b: got %h want 0", {b_c2o, b_d2o, b_busy, b_err});
    end
    n_cmp++;
    if ({c_c2o, c_d2o, c_busy, c_err} !== '0) begin
      n_bad++; $display("FAIL reset_c: got %h want 0", {c_c2o, c_d2o, c_busy, c_err});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [127:0] l5 = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
    int first, nresp, errc; logic [127:0] data; bit tmo;
    a_write(5, l5);
    a_collect(0, first, nresp, data, errc, tmo);
    n_cmp++;
    if ({tmo, first, nresp} !== {1'b0, 32'd4, 32'd1}) begin
      n_bad++; $display("FAIL basic_wr_resp: got tmo=%0d first=%0d n=%0d want 0/4/1", tmo, first, nresp);
    end
    n_cmp++;
    if (data[15:0] !== 16'h0) begin
      n_bad++; $display("FAIL basic_wr_d2: got %h want 0000", data[15:0]);
    end
    a_read(5, 1'b0);
    a_collect(0, first, nresp, data, errc, tmo);
    n_cmp++;
    if ({tmo, first, nresp} !== {1'b0, 32'd4, 32'd8}) begin
      n_bad++; $display("FAIL basic_rd_resp: got tmo=%0d first=%0d n=%0d want 0/4/8", tmo, first, nresp);
    end
    n_cmp++;
    if (data !== l5) begin
      n_bad++; $display("FAIL basic_rd_data: got %h want %h", data, l5);
    end
    n_cmp++;
    if (errc !== 0) begin
      n_bad++; $display("FAIL basic_rd_err: got %0d want 0", errc);
    end
  endtask

  task automatic test_busy_drop();
    logic [127:0] l1 = 128'h1F1E_1D1C_1B1A_1918_1716_1514_1312_1110;
    logic [127:0] l2 = 128'h2F2E_2D2C_2B2A_2928_2726_2524_2322_2120;
    int first, nresp, errc, strays; logic [127:0] data; bit tmo;
    a_write(2, l2); a_collect(0, first, nresp, data, errc, tmo);
    a_write(1, l1); a_collect(0, first, nresp, data, errc, tmo);
    a_read(1, 1'b1);
    a_collect(6, first, nresp, data, errc, tmo);
    n_cmp++;
    if ({tmo, nresp} !== {1'b0, 32'd8} || data !== l1) begin
      n_bad++; $display("FAIL drop_rd: got tmo=%0d n=%0d data=%h want 0/8/%h", tmo, nresp, data, l1);
    end
    strays = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (a_c2o == 2'd3 || a_busy) strays++;
    end
    n_cmp++;
    if (strays !== 0) begin
      n_bad++; $display("FAIL drop_stray: got %0d active cycles want 0", strays);
    end
    a_read(2, 1'b0);
    a_collect(0, first, nresp, data, errc, tmo);
    n_cmp++;
    if (data !== l2) begin
      n_bad++; $display("FAIL drop_line2: got %h want %h", data, l2);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [127:0] l7 = 128'h7F7E_7D7C_7B7A_7978_7776_7574_7372_7170;
    logic [127:0] lx = 128'hA7A7_A6A6_A5A5_A4A4_A3A3_A2A2_A1A1_A0A0;
    int first, nresp, errc; logic [127:0] data; bit tmo;
    a_write(7, l7); a_collect(0, first, nresp, data, errc, tmo);
    a_c2 = 2'd2; a_a2 = 7; a_d2 = lx[15:0];
    @(posedge clk); #1;
    a_c2 = 2'd0;
    for (int i = 1; i < 4; i++) begin
      a_d2 = lx[16*i +: 16];
      @(posedge clk); #1;
    end
    n_cmp++;
    if (a_busy !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", a_busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_c2o, a_d2o, a_busy, a_err} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got %h want 0", {a_c2o, a_d2o, a_busy, a_err});
    end
    #1 rst_n = 1'b1;
    a_d2 = '0;
    @(posedge clk); #1;
    a_read(7, 1'b0);
    a_collect(0, first, nresp, data, errc, tmo);
    n_cmp++;
    if ({tmo, nresp} !== {1'b0, 32'd8} || data !== l7) begin
      n_bad++; $display("FAIL rstmid_line7: got n=%0d data=%h want 8/%h", nresp, data, l7);
    end
  endtask

  task automatic test_latency();
    logic [127:0] lb = 128'hB7B6_B5B4_B3B2_B1B0_C7C6_C5C4_C3C2_C1C0;
    logic [15:0] exp_d; logic [1:0] exp_c; logic exp_b;
    b_c2 = 2'd2; b_a2 = 4; b_d2 = lb[15:0];
    @(posedge clk); #1;
    b_c2 = 2'd0;
    for (int i = 1; i < 8; i++) begin
      b_d2 = lb[16*i +: 16];
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({b_c2o, b_busy, b_d2o} !== {2'd3, 1'b1, 16'h0}) begin
      n_bad++; $display("FAIL lat1_wr_resp: got c2=%0d busy=%b d2=%h want 3/1/0000", b_c2o, b_busy, b_d2o);
    end
    @(posedge clk); #1;
    b_c2 = 2'd1; b_a2 = 4;
    @(posedge clk); #1;
    b_c2 = 2'd0;
    n_cmp++;
    if ({b_c2o, b_busy} !== {2'd0, 1'b1}) begin
      n_bad++; $display("FAIL lat1_cycle0: got c2=%0d busy=%b want 0/1", b_c2o, b_busy);
    end
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      if (n <= 8) begin
        exp_c = 2'd3; exp_b = 1'b1; exp_d = lb[16*(n-1) +: 16];
      end else begin
        exp_c = 2'd0; exp_b = 1'b0; exp_d = 16'h0;
      end
      n_cmp++;
      if ({b_c2o, b_busy, b_d2o} !== {exp_c, exp_b, exp_d}) begin
        n_bad++;
        $display("FAIL lat1_cycle%0d: got c2=%0d busy=%b d2=%h want %0d/%b/%h",
                 n, b_c2o, b_busy, b_d2o, exp_c, exp_b, exp_d);
      end
    end
  endtask

  task automatic test_width();
    logic [127:0] lc = 128'h00FF_EEDD_CCBB_AA99_8877_6655_4433_2211;
    logic [31:0] exp_d; logic [1:0] exp_c; logic exp_b;
    logic [31:0] beat0;
    c_c2 = 2'd2; c_a2 = 3; c_d2 = lc[31:0];
    @(posedge clk); #1;
    c_c2 = 2'd0;
    for (int i = 1; i < 4; i++) begin
      c_d2 = lc[32*i +: 32];
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if ({c_c2o, c_d2o} !== {2'd3, 32'h0}) begin
      n_bad++; $display("FAIL w32_wr_resp: got c2=%0d d2=%h want 3/0", c_c2o, c_d2o);
    end
    @(posedge clk); #1;
    c_c2 = 2'd1; c_a2 = 3;
    @(posedge clk); #1;
    c_c2 = 2'd0;
    beat0 = '0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (n >= 2 && n <= 5) begin
        exp_c = 2'd3; exp_b = 1'b1; exp_d = lc[32*(n-2) +: 32];
      end else begin
        exp_c = 2'd0; exp_b = (n == 1); exp_d = 32'h0;
      end
      if (n == 2) beat0 = c_d2o;
      n_cmp++;
      if ({c_c2o, c_busy, c_d2o} !== {exp_c, exp_b, exp_d}) begin
        n_bad++;
        $display("FAIL w32_cycle%0d: got c2=%0d busy=%b d2=%h want %0d/%b/%h",
                 n, c_c2o, c_busy, c_d2o, exp_c, exp_b, exp_d);
      end
    end
    n_cmp++;
    if (beat0[31:24] !== 8'h44) begin
      n_bad++; $display("FAIL w32_byte3: got %h want 44", beat0[31:24]);
    end
  endtask

  task automatic test_oor();
    logic [127:0] l0 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    logic [6:0] a64 = 7'd64;
    logic [127:0] exp_data;
    int exp_err;
    int first, nresp, errc; logic [127:0] data; bit tmo;
`ifdef MEM_LINE_CTRL_OOR_CHECK_EN
    exp_data = '0; exp_err = 8;
`else
    exp_data = l0; exp_err = 0;
`endif
    a_write(0, l0); a_collect(0, first, nresp, data, errc, tmo);
    a_read(a64[AW-1:0], 1'b0);
    a_collect(0, first, nresp, data, errc, tmo);
    n_cmp++;
    if ({tmo, first, nresp} !== {1'b0, 32'd4, 32'd8}) begin
      n_bad++; $display("FAIL oor_resp: got tmo=%0d first=%0d n=%0d want 0/4/8", tmo, first, nresp);
    end
    n_cmp++;
    if (data !== exp_data) begin
      n_bad++; $display("FAIL oor_data: got %h want %h", data, exp_data);
    end
    n_cmp++;
    if (errc !== exp_err) begin
      n_bad++; $display("FAIL oor_err: got %0d want %0d", errc, exp_err);
    end
  endtask

  initial begin
    a_c2 = '0; a_a2 = '0; a_d2 = '0;
    b_c2 = '0; b_a2 = '0; b_d2 = '0;
    c_c2 = '0; c_a2 = '0; c_d2 = '0;
    test_reset();
    test_basic();
    test_busy_drop();
    test_reset_mid_write();
    test_latency();
    test_width();
    test_oor();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
